// File: rtl/raster_cmd_queue.sv
// Line-record command queue between clipper and line generator, with a
// free-running frame timer that marks frame boundaries and end of objects.
module raster_cmd_queue #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned FRAME_TICKS = 1666667
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [68:0]              wr_data,
    input  logic                     wr_last,
    output logic                     full,
    output logic                     overflow,
    input  logic                     fifo_rd_en,
    output logic [68:0]              fifo_data,
    output logic                     fifo_empty,
    output logic                     end_of_objects,
    output logic                     frame_start,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned FCW = $clog2(FRAME_TICKS + 1);

    logic [69:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;
    logic [68:0]    data_q, data_d;
    logic           eoo_q, eoo_d;
    logic           fs_q, fs_d;
    logic [FCW-1:0] fc_q, fc_d;
    logic           wr_ok, rd_ok, fc_last;
    logic [69:0]    head;

    assign full           = (count_q == CW'(DEPTH));
    assign fifo_empty     = (count_q == '0);
    assign overflow       = ovf_q;
    assign fifo_data      = data_q;
    assign end_of_objects = eoo_q;
    assign frame_start    = fs_q;
    assign count          = count_q;

    always_comb begin
        wr_ok    = wr_en && !full;
        rd_ok    = fifo_rd_en && !fifo_empty;
        head     = mem[rd_ptr_q];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;
        eoo_d    = eoo_q;
        ovf_d    = ovf_q | (wr_en & full);

        if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            data_d   = head[68:0];
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        fc_last = (fc_q == FCW'(FRAME_TICKS - 1));
        fc_d    = fc_last ? '0 : fc_q + FCW'(1);
        fs_d    = fc_last;

        // A frame boundary clears the flag even if the last record pops now.
        if (fs_q)
            eoo_d = 1'b0;
        else if (rd_ok && head[69])
            eoo_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_q] <= {wr_last, wr_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            eoo_q    <= 1'b0;
            fs_q     <= 1'b0;
            fc_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            eoo_q    <= eoo_d;
            fs_q     <= fs_d;
            fc_q     <= fc_d;
        end
    end

endmodule

// File: tb/tb_raster_cmd_queue.sv
// Directed bench for raster_cmd_queue with a record scoreboard and a
// reference model of occupancy, overflow, frame timer and end-of-objects.
module tb_raster_cmd_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, wr_last, fifo_rd_en;
    logic [68:0] wr_data;
    logic        full, overflow, fifo_empty, end_of_objects, frame_start;
    logic [68:0] fifo_data;
    logic [4:0]  count;

    raster_cmd_queue #(.DEPTH(16), .FRAME_TICKS(10)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
        .full(full), .overflow(overflow), .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .end_of_objects(end_of_objects),
        .frame_start(frame_start), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [69:0] sb [$];
    int          m_count, m_fc;
    logic        m_ovf, m_eoo, m_fs;
    logic [68:0] m_data;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0; m_fc = 0; m_ovf = 1'b0; m_eoo = 1'b0; m_fs = 1'b0; m_data = '0;
    endtask

    function automatic logic [68:0] rnd_rec();
        return {$urandom, $urandom, $urandom};
    endfunction

    // One clock: drive inputs, advance the model, then check every output.
    task automatic step(input logic w, input logic [68:0] d, input logic l, input logic r);
        logic [69:0] rec;
        logic        wa, ra, fs_next;
        wr_en = w; wr_data = d; wr_last = l; fifo_rd_en = r;
        wa = w && (m_count < 16);
        ra = r && (m_count > 0);
        if (w && m_count == 16) m_ovf = 1'b1;
        if (m_fs) m_eoo = 1'b0;
        if (ra) begin
            rec    = sb.pop_front();
            m_data = rec[68:0];
            if (!m_fs && rec[69]) m_eoo = 1'b1;
        end
        if (wa) sb.push_back({l, d});
        m_count = m_count + int'(wa) - int'(ra);
        fs_next = (m_fc == 9);
        m_fc    = fs_next ? 0 : m_fc + 1;
        m_fs    = fs_next;
        @(posedge clk);
        #1;
        chk("count", count, m_count);
        chk("fifo_data", fifo_data, m_data);
        chk("fifo_empty", fifo_empty, m_count == 0);
        chk("full", full, m_count == 16);
        chk("overflow", overflow, m_ovf);
        chk("end_of_objects", end_of_objects, m_eoo);
        chk("frame_start", frame_start, m_fs);
        wr_en = 1'b0; fifo_rd_en = 1'b0; wr_last = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_frame(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            idle();
            if (frame_start === 1'b1) seen = 1'b1;
        end
        chk(tag, seen, 1'b1);
    endtask

    logic [68:0] recA, recB, r3;
    logic [68:0] recs [17];

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_last = 1'b0; fifo_rd_en = 1'b0; wr_data = '0;
        model_reset();
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", fifo_data, 0);
        chk("rst_eoo", end_of_objects, 0);
        chk("rst_fs", frame_start, 0);
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b1;

        // Basic write/pop path
        recA = rnd_rec(); recB = rnd_rec();
        step(1'b1, recA, 1'b0, 1'b0);
        step(1'b1, recB, 1'b0, 1'b0);
        chk("basic_cnt2", count, 2);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("basic_A", fifo_data, recA);
        chk("basic_cnt1", count, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("basic_B", fifo_data, recB);
        chk("basic_cnt0", count, 0);
        chk("basic_empty", fifo_empty, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("pop_empty_hold", fifo_data, recB);

        // Simultaneous write+pop at empty, then at count 5
        step(1'b1, rnd_rec(), 1'b0, 1'b1);
        chk("sim0_cnt", count, 1);
        chk("sim0_data", fifo_data, recB);
        for (int i = 0; i < 4; i++) step(1'b1, rnd_rec(), 1'b0, 1'b0);
        step(1'b1, rnd_rec(), 1'b0, 1'b1);
        chk("sim5_cnt", count, 5);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);

        // End of objects, aligned just after a frame boundary
        wait_frame("fs_sync1");
        step(1'b1, rnd_rec(), 1'b0, 1'b0);
        step(1'b1, rnd_rec(), 1'b0, 1'b0);
        r3 = rnd_rec();
        step(1'b1, r3, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("eoo_before", end_of_objects, 0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("eoo_rise_data", fifo_data, r3);
        chk("eoo_rise", end_of_objects, 1);
        wait_frame("fs_sync2");
        chk("eoo_at_fs", end_of_objects, 1);
        idle();
        chk("eoo_clear", end_of_objects, 0);

        // Last record popped on the frame_start edge: boundary wins
        step(1'b1, rnd_rec(), 1'b1, 1'b0);
        wait_frame("fs_sync3");
        step(1'b0, '0, 1'b0, 1'b1);
        chk("eoo_prio", end_of_objects, 0);

        // Full and overflow
        for (int i = 0; i < 17; i++) begin
            recs[i] = rnd_rec();
            step(1'b1, recs[i], 1'b0, 1'b0);
            if (i == 15) chk("full_16", full, 1);
        end
        chk("ovf_set", overflow, 1);
        chk("cnt_16", count, 16);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b0, 1'b1);
            chk("order", fifo_data, recs[i]);
        end
        chk("drained", fifo_empty, 1);
        for (int i = 0; i < 16; i++) step(1'b1, rnd_rec(), 1'b0, 1'b0);
        step(1'b1, rnd_rec(), 1'b0, 1'b1);
        chk("full_sim_cnt", count, 15);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, 1'b1);
        chk("pre_rst_cnt", count, 7);
        chk("pre_rst_ovf", overflow, 1);

        // Asynchronous reset mid-operation
        #2 rst = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", fifo_empty, 1);
        chk("arst_ovf", overflow, 0);
        chk("arst_full", full, 0);
        chk("arst_data", fifo_data, 0);
        model_reset();
        @(posedge clk); @(negedge clk);
        rst = 1'b1;

        // Frame timing from release
        for (int i = 1; i <= 21; i++) begin
            idle();
            chk("fs_tick", frame_start, (i == 10 || i == 20));
        end
        recA = rnd_rec();
        step(1'b1, recA, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("post_rst_data", fifo_data, recA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
